// File: rtl/pipe_seq_ctrl_if.sv
// Pipeline sequencing bundle: hazard inputs, stage controls, data-memory handshake.
// Ports: slave = controller side, master = pipeline/memory side.
// Optional PIPE_SEQ_PERF_EN adds stall_cycles, flush_events, mem_wait_cycles.
interface pipe_seq_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] if_id_rs1;
    logic [REG_W-1:0] if_id_rs2;
    logic             id_ex_memread;
    logic [REG_W-1:0] id_ex_rd;
    logic             ex_redirect;
    logic             ex_mem_access;
    logic             dmem_ack;
    logic             dmem_req;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic             mem_timeout;
`ifdef PIPE_SEQ_PERF_EN
    logic [15:0]      stall_cycles;
    logic [15:0]      flush_events;
    logic [15:0]      mem_wait_cycles;
`endif

    modport slave (
        input  if_id_rs1, if_id_rs2, id_ex_memread, id_ex_rd,
        input  ex_redirect, ex_mem_access, dmem_ack,
        output dmem_req, pc_en, if_id_en, if_id_flush,
        output id_ex_en, id_ex_flush, ex_mem_en,
        output mem_wb_bubble, mem_timeout
`ifdef PIPE_SEQ_PERF_EN
        , output stall_cycles, flush_events, mem_wait_cycles
`endif
    );

    modport master (
        output if_id_rs1, if_id_rs2, id_ex_memread, id_ex_rd,
        output ex_redirect, ex_mem_access, dmem_ack,
        input  dmem_req, pc_en, if_id_en, if_id_flush,
        input  id_ex_en, id_ex_flush, ex_mem_en,
        input  mem_wb_bubble, mem_timeout
`ifdef PIPE_SEQ_PERF_EN
        , input stall_cycles, flush_events, mem_wait_cycles
`endif
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, PC enable, hazard
// priority (mem stall > redirect > load-use) and dmem handshake with watchdog.
// Ports: clk, reset (async, active-high), ctl (pipe_seq_ctrl_if.slave).
// Macro PIPE_SEQ_PERF_EN adds saturating 16-bit performance counters.
module pipe_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int REG_W       = 5
) (
    input  logic           clk,
    input  logic           reset,
    pipe_seq_ctrl_if.slave ctl
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;
    localparam logic [7:0] TO_LIM   = 8'(MEM_TIMEOUT);

    logic [1:0] state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       lu;
    logic       adv;

    assign lu = ctl.id_ex_memread
              && (ctl.id_ex_rd != '0)
              && ((ctl.id_ex_rd == ctl.if_id_rs1)
                  || (ctl.id_ex_rd == ctl.if_id_rs2));

    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        adv               = 1'b0;
        ctl.dmem_req      = 1'b0;
        ctl.pc_en         = 1'b0;
        ctl.if_id_en      = 1'b0;
        ctl.if_id_flush   = 1'b0;
        ctl.id_ex_en      = 1'b0;
        ctl.id_ex_flush   = 1'b0;
        ctl.ex_mem_en     = 1'b0;
        ctl.mem_wb_bubble = 1'b0;
        ctl.mem_timeout   = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    ctl.dmem_req = ctl.ex_mem_access;
                    if (ctl.ex_mem_access && !ctl.dmem_ack) begin
                        ctl.mem_wb_bubble = 1'b1;
                        state_nx          = MEM_WAIT;
                        cnt_nx            = 8'd1;
                    end else begin
                        adv    = 1'b1;
                        cnt_nx = '0;
                    end
                end
                MEM_WAIT: begin
                    ctl.dmem_req = 1'b1;
                    if (!ctl.dmem_ack) begin
                        ctl.mem_wb_bubble = 1'b1;
                        cnt_nx            = cnt + 8'd1;
                        if (cnt == TO_LIM)
                            state_nx = ERR;
                    end else begin
                        // inputs were frozen during the wait, so any
                        // redirect/hazard is resolved exactly once here
                        adv      = 1'b1;
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end
                end
                ERR: begin
                    ctl.mem_wb_bubble = 1'b1;
                    ctl.mem_timeout   = 1'b1;
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
        if (adv) begin
            ctl.pc_en     = 1'b1;
            ctl.if_id_en  = 1'b1;
            ctl.id_ex_en  = 1'b1;
            ctl.ex_mem_en = 1'b1;
            if (ctl.ex_redirect) begin
                // younger instruction is squashed, so lu is moot
                ctl.if_id_flush = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end else if (lu) begin
                ctl.pc_en       = 1'b0;
                ctl.if_id_en    = 1'b0;
                ctl.id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef PIPE_SEQ_PERF_EN
    logic [15:0] stall_q, flush_q, mwait_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            mwait_q <= '0;
        end else begin
            if (!ctl.pc_en && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (ctl.id_ex_flush && flush_q != 16'hFFFF)
                flush_q <= flush_q + 16'd1;
            if (state == MEM_WAIT && mwait_q != 16'hFFFF)
                mwait_q <= mwait_q + 16'd1;
        end
    end

    assign ctl.stall_cycles    = stall_q;
    assign ctl.flush_events    = flush_q;
    assign ctl.mem_wait_cycles = mwait_q;
`endif
endmodule

// File: doc/pipe_seq_ctrl.md
Name: pipe_seq_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline buffer registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-register enable and flush controls and the PC enable.
- Resolves three hazard sources by fixed priority: multi-cycle data-memory access stalls, EX-stage control redirects, and load-use hazards.
- Owns the data-memory request/acknowledge handshake, including a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before the error state is entered; legal range 1..255.
- REG_W, 5: register-index width.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_id_rs1  in  REG_W  RS_One of the instruction in IF/ID
- if_id_rs2  in  REG_W  RS_Two of the instruction in IF/ID
- id_ex_memread  in  1  ID/EX MemRead
- id_ex_rd  in  REG_W  ID/EX rd
- ex_redirect  in  1  branch taken, Jump or JalrSel resolved in EX this cycle
- ex_mem_access  in  1  EX/MEM MemRead or MemWrite is set
- dmem_ack  in  1  data-memory completion; may arrive in the same cycle as the request
- dmem_req  out  1  data-memory request
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID synchronous clear
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX synchronous clear, inserts a bubble
- ex_mem_en  out  1  EX/MEM load enable
- mem_wb_bubble  out  1  load a bubble into MEM/WB (RegWrite=0)
- mem_timeout  out  1  sticky error flag

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. State and the wait counter (8 bit) are the only registered elements, apart from the optional counters. All other outputs are combinational from state and inputs.
- While reset is high, and immediately after it deasserts:
  - state=RUN, wait counter=0, mem_timeout=0.
  - While reset is asserted, all enables, flushes, dmem_req and mem_wb_bubble are forced to 0.
- Flush has precedence over enable at the destination register. The register clears at the next clk edge.
- Load-use hazard term: lu = id_ex_memread & (id_ex_rd != 0) & (id_ex_rd == if_id_rs1 | id_ex_rd == if_id_rs2).
- RUN:
  - dmem_req = ex_mem_access.
  - Memory stall (ex_mem_access & !dmem_ack):
    - pc_en, if_id_en, id_ex_en and ex_mem_en are all 0; mem_mem_wb_bubble-free wording aside, mem_wb_bubble=1; no flushes.
    - Next state MEM_WAIT, counter loaded with 1.
  - Otherwise, the "advance rules" apply:
    - All enables are 1 and mem_wb_bubble=0.
    - If ex_redirect: if_id_flush=1 and id_ex_flush=1. lu is ignored because the younger instruction is squashed.
    - Else if lu: pc_en=0, if_id_en=0, id_ex_flush=1 (one bubble).
    - Else no flushes.
- MEM_WAIT:
  - dmem_req=1 is held.
  - On !dmem_ack:
    - Pipeline frozen as in the RUN memory-stall case; counter increments.
    - If the counter equals MEM_TIMEOUT, next state is ERR.
  - On dmem_ack:
    - The advance rules apply in that same cycle, evaluated on the current (frozen, stable) inputs.
    - Next state RUN, counter cleared.
  - A pending redirect or hazard is therefore neither lost nor duplicated.
- ERR:
  - dmem_req=0, all enables 0, mem_wb_bubble=1, mem_timeout=1.
  - Exited only by reset.
- Simultaneous events:
  - A memory stall overrides redirect and lu.
  - Redirect overrides lu.
  - An ack arriving at counter==MEM_TIMEOUT is honoured, and the FSM returns to RUN rather than ERR.
- id_ex_rd == 0 never raises lu.
- Reset mid-MEM_WAIT aborts the request, with dmem_req dropping asynchronously.

Optional Feature:
- Macro: PIPE_SEQ_PERF_EN.
- When defined, adds three outputs: stall_cycles (out, 16), flush_events (out, 16) and mem_wait_cycles (out, 16). All are saturating at 0xFFFF and reset to 0.
  - stall_cycles increments on each cycle with pc_en=0 outside reset.
  - flush_events increments on each cycle with id_ex_flush=1.
  - mem_wait_cycles increments on each cycle spent in MEM_WAIT.
- When undefined, these ports and their counters do not exist. Core behaviour is identical in both cases.

Test Plan:
- Load-use hazard:
  - Stimulus: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5, no memory access.
  - Response: exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. When id_ex_memread drops, the next cycle has all enables 1.
- x0 exemption:
  - Stimulus: same as the load-use case but id_ex_rd=0.
  - Response: no stall and no flush.
- Redirect with concurrent hazard:
  - Stimulus: ex_redirect=1 together with lu=1.
  - Response: if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_en=1.
- Memory wait:
  - Stimulus: ex_mem_access=1, ack after 3 cycles.
  - Response: dmem_req=1 for 4 cycles; enables 0 and mem_wb_bubble=1 for 3 cycles; 4th cycle all enables 1; state returns to RUN. With PIPE_SEQ_PERF_EN defined, mem_wait_cycles=3.
- Memory wait with pending redirect:
  - Stimulus: memory access with ack after 2 cycles while ex_redirect=1 throughout.
  - Response: flushes only on the ack cycle; flush_events increments by exactly 1.
- Timeout and recovery:
  - Stimulus: MEM_TIMEOUT=4, ack never arrives.
  - Response: ERR entered after 4 MEM_WAIT cycles; mem_timeout=1 and dmem_req=0.
  - Follow-up stimulus: assert reset mid-ERR.
  - Response: all outputs go to reset values asynchronously, and the FSM resumes in RUN after reset deasserts.
